// File: rtl/spatial_filter_pkg.sv
// Shared constants and FSM encoding for the 3x3 spatial filter front end.
package spatial_filter_pkg;

  localparam int PIX_W      = 8;
  localparam int KERNEL_DIM = 3;
  localparam int WIN_W      = KERNEL_DIM * KERNEL_DIM * PIX_W;
  localparam int NUM_LB     = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RD   = 1'b1
  } rd_state_t;

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage; a read returns three consecutive pixels,
// wrapping at the end of the line, through an output register.
module line_buffer
  import spatial_filter_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  parameter int AW        = $clog2(IMG_WIDTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [PIX_W-1:0]            wr_data,
  input  logic                        rd_en,
  input  logic [AW-1:0]               rd_addr,
  output logic [KERNEL_DIM*PIX_W-1:0] rd_data
);

  localparam logic [AW-1:0] LAST = AW'(IMG_WIDTH - 1);

  logic [PIX_W-1:0] mem [IMG_WIDTH];
  logic [AW-1:0]    addr_1;
  logic [AW-1:0]    addr_2;

  always_comb begin
    addr_1 = (rd_addr == LAST) ? '0 : rd_addr + AW'(1);
    addr_2 = (addr_1 == LAST) ? '0 : addr_1 + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Left-most column lands in the low byte; a same-cycle write is not seen.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else if (rd_en) rd_data <= {mem[addr_2], mem[addr_1], mem[rd_addr]};
  end

endmodule

// File: rtl/line_buffer_window_ctrl.sv
// Rotating four-line store feeding one 3x3 window per cycle to the convolution
// stage, with a one-cycle interrupt after every consumed line.
module line_buffer_window_ctrl
  import spatial_filter_pkg::*;
#(
  parameter int IMG_WIDTH = 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] i_pixel_data,
  input  logic             i_pixel_data_valid,
  output logic [WIN_W-1:0] o_pixel_data,
  output logic             o_pixel_data_valid,
  output logic             o_intr
);

  // Handshake: i_pixel_data_valid has no backpressure, so a pixel offered while
  // all four lines are occupied is dropped; o_pixel_data_valid marks each window
  // for exactly one cycle and o_pixel_data holds between windows.

  localparam int AW = $clog2(IMG_WIDTH);
  localparam int CW = $clog2(4 * IMG_WIDTH + 1);
  localparam logic [AW-1:0] LAST   = AW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] FULL   = CW'(4 * IMG_WIDTH);
  localparam logic [CW-1:0] THRESH = CW'(3 * IMG_WIDTH);

  rd_state_t     state;
  logic [AW-1:0] wr_ptr;
  logic [1:0]    wr_sel;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    rd_sel;
  logic [1:0]    win_sel;
  logic [CW-1:0] fill_cnt;
  logic          last_rd;
  logic          wr_en;
  logic          rd_en;

  logic [KERNEL_DIM*PIX_W-1:0] lb_q [NUM_LB];
  logic [1:0]                  row_mid;
  logic [1:0]                  row_bot;

  assign wr_en = i_pixel_data_valid && (fill_cnt != FULL);
  assign rd_en = (state == ST_RD);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      wr_sel <= '0;
    end else if (wr_en) begin
      if (wr_ptr == LAST) begin
        wr_ptr <= '0;
        wr_sel <= wr_sel + 2'd1;
      end else begin
        wr_ptr <= wr_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) fill_cnt <= '0;
    else if (wr_en && !rd_en) fill_cnt <= fill_cnt + CW'(1);
    else if (rd_en && !wr_en) fill_cnt <= fill_cnt - CW'(1);
  end

  // last_rd delays the interrupt so it lands the cycle after the final window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      rd_ptr             <= '0;
      rd_sel             <= '0;
      win_sel            <= '0;
      last_rd            <= 1'b0;
      o_intr             <= 1'b0;
      o_pixel_data_valid <= 1'b0;
    end else begin
      o_pixel_data_valid <= rd_en;
      o_intr             <= last_rd;
      last_rd            <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fill_cnt >= THRESH) begin
            state  <= ST_RD;
            rd_ptr <= '0;
          end
        end
        ST_RD: begin
          win_sel <= rd_sel;
          if (rd_ptr == LAST) begin
            rd_ptr  <= '0;
            rd_sel  <= rd_sel + 2'd1;
            last_rd <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            rd_ptr <= rd_ptr + AW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LB; i++) begin : g_lb
    line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_lb (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en && (wr_sel == 2'(i))),
      .wr_addr (wr_ptr),
      .wr_data (i_pixel_data),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr),
      .rd_data (lb_q[i])
    );
  end

  assign row_mid      = win_sel + 2'd1;
  assign row_bot      = win_sel + 2'd2;
  assign o_pixel_data = {lb_q[row_bot], lb_q[row_mid], lb_q[win_sel]};

endmodule

// File: tb/tb_line_buffer_window_ctrl.sv
// Randomized bench for line_buffer_window_ctrl with a line-level reference model
// and a decoupled window/interrupt scoreboard.
module tb_line_buffer_window_ctrl;

  localparam int IMG_W = 8;
  localparam int PW    = 8;
  localparam int WIN   = 9 * PW;

  logic           clk       = 1'b0;
  logic           reset     = 1'b1;
  logic [PW-1:0]  pix       = '0;
  logic           pix_valid = 1'b0;
  logic [WIN-1:0] win;
  logic           win_valid;
  logic           intr;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_intr = 0;
  int run    = 0;
  int last_v = -10;
  int pct    = 100;
  bit ev;
  bit ei;
  bit chk_hold    = 1'b0;
  bit chk_rst_now = 1'b0;

  logic [WIN-1:0] exp_q[$];
  int             exp_cyc_q[$];
  int             intr_q[$];
  logic [WIN-1:0] got_q[$];

  // reference model: four line slots plus occupancy and read-pass bookkeeping
  logic [PW-1:0]  m_mem [4][IMG_W];
  int             m_fill, m_wsel, m_wptr, m_rsel, m_rptr;
  bit             m_reading;
  logic [WIN-1:0] m_last;

  line_buffer_window_ctrl #(.IMG_WIDTH(IMG_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .i_pixel_data       (pix),
    .i_pixel_data_valid (pix_valid),
    .o_pixel_data       (win),
    .o_pixel_data_valid (win_valid),
    .o_intr             (intr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WIN-1:0] got, input logic [WIN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Predicts the effect of the coming clock edge from the rules for the store.
  task automatic model_step(input bit rst, input bit v, input logic [PW-1:0] d);
    int e;
    bit rd, wr;
    logic [WIN-1:0] w;
    e = cyc + 1;
    if (rst) begin
      m_fill = 0; m_wsel = 0; m_wptr = 0; m_rsel = 0; m_rptr = 0;
      m_reading = 1'b0;
      m_last = '0;
      while (intr_q.size() > 0 && intr_q[$] >= e) void'(intr_q.pop_back());
      return;
    end
    rd = m_reading;
    wr = v && (m_fill < 4 * IMG_W);
    if (rd) begin
      w = '0;
      for (int k = 0; k < 9; k++)
        w[k*PW +: PW] = m_mem[(m_rsel + k / 3) % 4][(m_rptr + k % 3) % IMG_W];
      exp_q.push_back(w);
      exp_cyc_q.push_back(e);
      m_last = w;
      if (m_rptr == IMG_W - 1) intr_q.push_back(e + 1);
    end
    if (wr) begin
      m_mem[m_wsel][m_wptr] = d;
      m_wptr++;
      if (m_wptr == IMG_W) begin
        m_wptr = 0;
        m_wsel = (m_wsel + 1) % 4;
      end
    end
    if (rd) begin
      m_rptr++;
      if (m_rptr == IMG_W) begin
        m_rptr = 0;
        m_rsel = (m_rsel + 1) % 4;
        m_reading = 1'b0;
      end
    end else if (m_fill >= 3 * IMG_W) begin
      m_reading = 1'b1;
      m_rptr = 0;
    end
    m_fill = m_fill + int'(wr) - int'(rd);
  endtask

  task automatic drive(input bit rst, input bit v, input logic [PW-1:0] d);
    @(negedge clk);
    if (chk_hold) check("window_hold", win, m_last);
    if (chk_rst_now) begin
      check("reset_valid", WIN'(win_valid), '0);
      check("reset_intr", WIN'(intr), '0);
      chk_rst_now = 1'b0;
    end
    reset     = rst;
    pix_valid = v;
    pix       = d;
    model_step(rst, v, d);
    if (rst) chk_hold = 1'b1;
  endtask

  // monitor: pops the scoreboard whenever a window or interrupt is due or seen
  initial begin
    forever begin
      @(negedge clk);
      ev = exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc;
      if (ev || win_valid !== 1'b0) begin
        check("window_valid", WIN'(win_valid), WIN'(ev));
        if (ev) begin
          check("window_data", win, exp_q[0]);
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
      end
      if (win_valid === 1'b1) begin
        got_q.push_back(win);
        run    = (last_v == cyc - 1) ? run + 1 : 1;
        last_v = cyc;
      end
      ei = intr_q.size() > 0 && intr_q[0] == cyc;
      if (ei || intr !== 1'b0) begin
        check("intr", WIN'(intr), WIN'(ei));
        if (ei) void'(intr_q.pop_front());
        if (intr === 1'b1) begin
          n_intr++;
          check("valids_per_intr", WIN'(run), WIN'(IMG_W));
          check("intr_after_last_valid", WIN'(last_v), WIN'(cyc - 1));
        end
      end
    end
  end

  initial begin
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, '0);

    // lines 0..4 back to back, pixel = line*16 + col
    for (int l = 0; l < 5; l++)
      for (int c = 0; c < IMG_W; c++)
        drive(1'b0, 1'b1, PW'(l * 16 + c));
    repeat (30) drive(1'b0, 1'b0, '0);
    check("intr_count_5_lines", WIN'(n_intr), WIN'(3));
    check("window_count_5_lines", WIN'(got_q.size()), WIN'(3 * IMG_W));
    if (got_q.size() >= 3 * IMG_W) begin
      check("first_window", got_q[0], 72'h22_21_20_12_11_10_02_01_00);
      check("wrap_window", got_q[7], 72'h21_20_27_11_10_17_01_00_07);
      check("second_pass_rows", got_q[8], 72'h32_31_30_22_21_20_12_11_10);
      check("third_pass_rows", got_q[16], 72'h42_41_40_32_31_30_22_21_20);
    end

    // reset in the middle of a read pass, then refill from scratch
    for (int c = 0; c < 14; c++) drive(1'b0, 1'b1, PW'($urandom_range(0, 255)));
    drive(1'b1, 1'b1, PW'($urandom_range(0, 255)));
    drive(1'b1, 1'b0, '0);
    chk_rst_now = 1'b1;
    drive(1'b0, 1'b0, '0);
    check("reset_data", win, '0);
    chk_rst_now = 1'b1;
    for (int c = 0; c < 23; c++) drive(1'b0, 1'b1, PW'($urandom_range(0, 255)));
    repeat (6) drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, PW'($urandom_range(0, 255)));
    repeat (20) drive(1'b0, 1'b0, '0);

    // random density segments; full-rate segments push the store into overflow
    for (int seg = 0; seg < 12; seg++) begin
      pct = (seg % 3 == 0) ? 100 : int'($urandom_range(30, 95));
      if (seg == 7) begin
        drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
      end
      repeat (150) drive(1'b0, $urandom_range(0, 99) < pct, PW'($urandom_range(0, 255)));
    end

    repeat (40) drive(1'b0, 1'b0, '0);
    check("pending_windows", WIN'(exp_q.size()), '0);
    check("pending_intr", WIN'(intr_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
